// File: rtl/muldiv_sequencer_pkg.sv
// Shared pipeline encodings for the M-extension sequencer: funct3 operations,
// FSM states, iteration count and ALU control codes.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    localparam int ITERATIONS = 32;
    localparam int COUNT_W    = 5;

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic negative);
        return negative ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the pipeline (master) and the mul/div sequencer (slave).
interface muldiv_sequencer_if;

    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [63:0] opa_in,
    input  logic [31:0] opb_in,
    output logic [63:0] acc_out,
    output logic [63:0] opa_out,
    output logic [31:0] opb_out
);

    logic [32:0] rem_shift;
    logic [32:0] trial;

    // Divide: acc holds the partial remainder, opa the dividend bits shifting
    // out at the top while quotient bits shift in at the bottom.
    always_comb begin
        rem_shift = {acc_in[31:0], opa_in[31]};
        trial     = rem_shift - {1'b0, opb_in};
        acc_out   = acc_in;
        opa_out   = opa_in;
        opb_out   = opb_in;
        if (is_div) begin
            if (!trial[32]) begin
                acc_out = {32'd0, trial[31:0]};
                opa_out = {32'd0, opa_in[30:0], 1'b1};
            end else begin
                acc_out = {32'd0, rem_shift[31:0]};
                opa_out = {32'd0, opa_in[30:0], 1'b0};
            end
        end else begin
            acc_out = opb_in[0] ? (acc_in + opa_in) : acc_in;
            opa_out = {opa_in[62:0], 1'b0};
            opb_out = {1'b0, opb_in[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: 32 radix-2 iterations on magnitudes,
// sign fix-up in FIX, single-cycle fast paths for divide-by-zero and overflow.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    muldiv_sequencer_if.slave  bus
);

    state_e               state, state_next;
    funct3_e              op, req_op;
    logic                 sign_a, sign_b;
    logic [COUNT_W-1:0]   count;
    logic [63:0]          acc, opnd_a;
    logic [31:0]          opnd_b;
    logic [31:0]          result_q;

    logic                 req_sign_a, req_sign_b, div_by_zero, overflow, req_fast, accept;
    logic [31:0]          fast_value;
    logic [63:0]          step_acc, step_opa;
    logic [31:0]          step_opb;
    logic [63:0]          prod_fixed;
    logic [31:0]          quot_fixed, rem_fixed, fix_value;

    always_comb begin
        req_op      = funct3_e'(bus.funct3);
        req_sign_a  = (req_op inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM}) && bus.op_a[31];
        req_sign_b  = (req_op inside {F3_MULH, F3_DIV, F3_REM}) && bus.op_b[31];
        div_by_zero = bus.funct3[2] && (bus.op_b == 32'd0);
        overflow    = (req_op inside {F3_DIV, F3_REM}) &&
                      (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
        req_fast    = div_by_zero || overflow;
        accept      = (state == IDLE) && bus.start && !bus.flush;
        fast_value  = 32'd0;
        if (div_by_zero)
            fast_value = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
        else
            fast_value = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = req_fast ? DONE : CALC;
                CALC:    if (count == COUNT_W'(ITERATIONS - 1)) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        bus.result = result_q;
    end

    muldiv_step u_step (
        .is_div  (op[2]),
        .acc_in  (acc),
        .opa_in  (opnd_a),
        .opb_in  (opnd_b),
        .acc_out (step_acc),
        .opa_out (step_opa),
        .opb_out (step_opb)
    );

    // Quotient follows the sign mismatch, remainder follows the dividend.
    always_comb begin
        prod_fixed = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
        quot_fixed = (sign_a ^ sign_b) ? (~opnd_a[31:0] + 32'd1) : opnd_a[31:0];
        rem_fixed  = sign_a ? (~acc[31:0] + 32'd1) : acc[31:0];
        case (op)
            F3_MUL:                         fix_value = prod_fixed[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   fix_value = prod_fixed[63:32];
            F3_DIV, F3_DIVU:                fix_value = quot_fixed;
            default:                        fix_value = rem_fixed;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op       <= F3_MUL;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            count    <= '0;
            acc      <= 64'd0;
            opnd_a   <= 64'd0;
            opnd_b   <= 32'd0;
            result_q <= 32'd0;
        end else if (accept) begin
            op     <= req_op;
            sign_a <= req_sign_a;
            sign_b <= req_sign_b;
            count  <= '0;
            acc    <= 64'd0;
            opnd_a <= {32'd0, magnitude(bus.op_a, req_sign_a)};
            opnd_b <= magnitude(bus.op_b, req_sign_b);
            if (req_fast)
                result_q <= fast_value;
        end else if (state == CALC && !bus.flush) begin
            acc    <= step_acc;
            opnd_a <= step_opa;
            opnd_b <= step_opb;
            count  <= count + COUNT_W'(1);
        end else if (state == FIX && !bus.flush) begin
            result_q <= fix_value;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, fast paths,
// flush/reset aborts, back-to-back issue and a batch of random operations.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    typedef struct {
        logic [31:0] value;
        int          issue;
        int          latency;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cycle = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    expect_t     scoreboard[$];
    expect_t     monExpect;
    logic [31:0] lastResult = 32'd0;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] u;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'b000: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
            3'b001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'b010: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'b011: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                monExpect = scoreboard.pop_front();
                checkOutput("result", bus.result, monExpect.value);
                checkOutput("latency", 32'(cycle - monExpect.issue), 32'(monExpect.latency));
                lastResult = monExpect.value;
            end
        end
    end

    // Called #1 after a rising edge in an IDLE cycle; returns in the IDLE cycle after done.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected, input int latency);
        expect_t e;
        bit      seen;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        e.value    = expected;
        e.issue    = cycle;
        e.latency  = latency;
        scoreboard.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("busy_after_start", {31'd0, bus.busy}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            scoreboard.delete();
        end
        @(posedge clk); #1;
        checkOutput("idle_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic issueUnchecked(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, issued back-to-back in the IDLE cycle after each done.
        applyStimulus(F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        applyStimulus(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        applyStimulus(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34);
        applyStimulus(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        applyStimulus(F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        applyStimulus(F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        applyStimulus(F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        applyStimulus(F3_REMU,   32'd5,          32'd0,         32'd5,         1);
        applyStimulus(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        applyStimulus(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);
        applyStimulus(F3_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1);
        applyStimulus(F3_DIVU,   32'd100,        32'd7,         32'd14,        34);
        applyStimulus(F3_REMU,   32'd100,        32'd7,         32'd2,         34);

        // Flush at T+10 of a MUL: no done, result held, restart at T+11 finishes at T+45.
        issueUnchecked(F3_MUL, 32'd1234, 32'd5678);
        repeat (9) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checkOutput("flush_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("flush_result_held", bus.result, lastResult);
        applyStimulus(F3_MUL, 32'd1234, 32'd5678, 32'd7006652, 34);

        // Flush and start together in IDLE: request is dropped.
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.funct3 = F3_DIVU;
        bus.op_b   = 32'd0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        checkOutput("flush_start_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        checkOutput("flush_start_result", bus.result, lastResult);

        // Reset at T+5 of a DIV clears everything including result.
        issueUnchecked(F3_DIV, 32'd1000, 32'd3);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_mid_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_mid_result", bus.result, 32'd0);
        rst = 1'b0;
        lastResult = 32'd0;
        @(posedge clk); #1;

        // Random mix, occasionally forcing a zero divisor or the overflow pair.
        for (int n = 0; n < 24; n++) begin
            f3 = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15, 1));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            applyStimulus(f3, a, b, refResult(f3, a, b), refLatency(f3, a, b));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
